// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter (master side) and the cache pair plus memory model (slave side).
interface mem_arbiter_if #(
    parameter int WORDS = 8
);
    localparam int WW = $clog2(WORDS);

    logic          ic_fill_req;
    logic [15:0]   ic_fill_addr;
    logic          dc_fill_req;
    logic [15:0]   dc_fill_addr;
    logic          dc_wr_req;
    logic [15:0]   dc_wr_addr;
    logic [15:0]   dc_wr_data;
    logic          mem_enable;
    logic          mem_wr;
    logic [15:0]   mem_addr;
    logic [15:0]   mem_data_in;
    logic [15:0]   mem_data_out;
    logic          mem_data_valid;
    logic [15:0]   fill_data;
    logic [WW-1:0] fill_word;
    logic          ic_fill_we;
    logic          dc_fill_we;
    logic          ic_fill_done;
    logic          dc_fill_done;
    logic          dc_wr_done;
    logic          busy;

    modport master (
        input  ic_fill_req, ic_fill_addr, dc_fill_req, dc_fill_addr,
        input  dc_wr_req, dc_wr_addr, dc_wr_data, mem_data_out, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
        output ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy
    );

    modport slave (
        output ic_fill_req, ic_fill_addr, dc_fill_req, dc_fill_addr,
        output dc_wr_req, dc_wr_addr, dc_wr_data, mem_data_out, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
        input  ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the pipelined memory port between D-cache stores, D-cache fills and I-cache fills.
// Define MEM_ARB_RR_EN for I/D round-robin; otherwise fixed priority D store > D fill > I fill.
module mem_arbiter #(
    parameter int WORDS = 8
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int WW = $clog2(WORDS);
    localparam int CW = WW + 1;
    localparam int BW = 15 - WW;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(WORDS);

    typedef enum logic [1:0] {IDLE, DWR, DFILL, IFILL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] issue_q, issue_d;
    logic [CW-1:0] ret_q, ret_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          d_first;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    // The D side yields only when it was served last and the I side is waiting.
    always_comb begin
        last_d_d = last_d_q;
        if (bus.dc_wr_done || bus.dc_fill_done) begin
            last_d_d = 1'b1;
        end else if (bus.ic_fill_done) begin
            last_d_d = 1'b0;
        end
        d_first = !last_d_q || !bus.ic_fill_req;
    end
`else
    assign d_first = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            issue_q <= '0;
            ret_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        issue_d          = issue_q;
        ret_d            = ret_q;
        blk_d            = blk_q;
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.fill_data    = bus.mem_data_out;
        bus.fill_word    = ret_q[WW-1:0];
        bus.ic_fill_we   = 1'b0;
        bus.dc_fill_we   = 1'b0;
        bus.ic_fill_done = 1'b0;
        bus.dc_fill_done = 1'b0;
        bus.dc_wr_done   = 1'b0;
        bus.busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                issue_d = '0;
                ret_d   = '0;
                if (d_first && bus.dc_wr_req) begin
                    state_d = DWR;
                end else if (d_first && bus.dc_fill_req) begin
                    state_d = DFILL;
                    blk_d   = bus.dc_fill_addr[15:WW+1];
                end else if (bus.ic_fill_req) begin
                    state_d = IFILL;
                    blk_d   = bus.ic_fill_addr[15:WW+1];
                end
            end

            // Single store: issue once, then wait for the write acknowledge.
            DWR: begin
                if (issue_q == '0) begin
                    bus.mem_enable  = 1'b1;
                    bus.mem_wr      = 1'b1;
                    bus.mem_addr    = bus.dc_wr_addr;
                    bus.mem_data_in = bus.dc_wr_data;
                    issue_d         = CW'(1);
                end
                if (bus.mem_data_valid) begin
                    bus.dc_wr_done = 1'b1;
                    state_d        = IDLE;
                end
            end

            // Issue and return counters stop at WORDS, so a burst never wraps.
            DFILL, IFILL: begin
                if (issue_q != FULL) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = {blk_q, issue_q[WW-1:0], 1'b0};
                    issue_d        = issue_q + 1'b1;
                end
                if (bus.mem_data_valid) begin
                    if (state_q == DFILL) begin
                        bus.dc_fill_we = 1'b1;
                    end else begin
                        bus.ic_fill_we = 1'b1;
                    end
                    ret_d = ret_q + 1'b1;
                    if (ret_q == LAST) begin
                        if (state_q == DFILL) begin
                            bus.dc_fill_done = 1'b1;
                        end else begin
                            bus.ic_fill_done = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency pipelined memory model (WORDS=8, MEM_LAT=4).
module tb_mem_arbiter;
    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if #(.WORDS(WORDS)) bus();

    mem_arbiter #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: responds exactly MEM_LAT cycles after each request; not reset, so stale responses survive rst.
    logic [MEM_LAT-1:0] vpipe = '0;
    logic [15:0]        dpipe [MEM_LAT] = '{default: 16'h0000};

    always @(posedge clk) begin
        vpipe    <= {vpipe[MEM_LAT-2:0], bus.mem_enable};
        dpipe[0] <= bus.mem_wr ? 16'h0000 : rd_model(bus.mem_addr);
        for (int i = 1; i < MEM_LAT; i++) dpipe[i] <= dpipe[i-1];
    end

    assign bus.mem_data_valid = vpipe[MEM_LAT-1];
    assign bus.mem_data_out   = dpipe[MEM_LAT-1];

    typedef struct {
        logic        ic_req;
        logic        en;
        logic [15:0] addr;
        logic        we;
        logic [2:0]  word;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic wd, fd, id;
    logic sides[$];
    int   stale, icwe_early, n, dcyc, icount;
    logic found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 1'b0, 1'b1},
            '{1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1, 1'b1},
            '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0}
        };

        bus.ic_fill_req  = 1'b0;
        bus.ic_fill_addr = 16'h0000;
        bus.dc_fill_req  = 1'b0;
        bus.dc_fill_addr = 16'h0000;
        bus.dc_wr_req    = 1'b0;
        bus.dc_wr_addr   = 16'h0000;
        bus.dc_wr_data   = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_enable", bus.mem_enable, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_data_in", bus.mem_data_in, 0);
        chk("rst_fill_word", bus.fill_word, 0);
        chk("rst_ic_fill_we", bus.ic_fill_we, 0);
        chk("rst_dc_fill_we", bus.dc_fill_we, 0);
        chk("rst_dones", {bus.ic_fill_done, bus.dc_fill_done, bus.dc_wr_done}, 0);
        next_cycle();
        rst = 1'b0;

        // Reset in the middle of a D fill, cycle 6
        bus.dc_fill_addr = 16'h3000;
        bus.dc_fill_req  = 1'b1;
        for (int c = 0; c < 6; c++) next_cycle();
        chk("midrst_busy_before", bus.busy, 1);
        rst = 1'b1;
        bus.dc_fill_req = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_mem_enable", bus.mem_enable, 0);
        chk("midrst_mem_addr", bus.mem_addr, 0);
        chk("midrst_dc_fill_we", bus.dc_fill_we, 0);
        chk("midrst_fill_word", bus.fill_word, 0);
        next_cycle();
        rst = 1'b0;
        stale = 0;
        for (int c = 7; c <= 12; c++) begin
            @(negedge clk);
            if (bus.mem_data_valid) stale++;
            chk($sformatf("stale_dc_fill_we_c%0d", c), bus.dc_fill_we, 0);
            chk($sformatf("stale_busy_c%0d", c), bus.busy, 0);
            next_cycle();
        end

        // I fill of 0x1236 from the vector table
        bus.ic_fill_addr = 16'h1236;
        for (int c = 0; c < 14; c++) begin
            bus.ic_fill_req = tbl[c].ic_req;
            @(negedge clk);
            chk($sformatf("ifill_en_c%0d", c), bus.mem_enable, tbl[c].en);
            chk($sformatf("ifill_busy_c%0d", c), bus.busy, tbl[c].busy);
            chk($sformatf("ifill_we_c%0d", c), bus.ic_fill_we, tbl[c].we);
            chk($sformatf("ifill_done_c%0d", c), bus.ic_fill_done, tbl[c].done);
            chk($sformatf("ifill_dc_we_c%0d", c), bus.dc_fill_we, 0);
            if (tbl[c].en) begin
                chk($sformatf("ifill_addr_c%0d", c), bus.mem_addr, tbl[c].addr);
                chk($sformatf("ifill_wr_c%0d", c), bus.mem_wr, 0);
            end
            if (tbl[c].we) begin
                chk($sformatf("ifill_word_c%0d", c), bus.fill_word, tbl[c].word);
                chk($sformatf("ifill_data_c%0d", c), bus.fill_data,
                    rd_model(16'h1230 + 16'(tbl[c].word) * 16'd2));
            end
            next_cycle();
        end

        // Write-through store
        bus.dc_wr_addr = 16'h0040;
        bus.dc_wr_data = 16'hBEEF;
        for (int c = 0; c <= 6; c++) begin
            bus.dc_wr_req = (c <= 5);
            @(negedge clk);
            chk($sformatf("wr_en_c%0d", c), bus.mem_enable, (c == 1));
            chk($sformatf("wr_done_c%0d", c), bus.dc_wr_done, (c == 5));
            chk($sformatf("wr_busy_c%0d", c), bus.busy, (c >= 1 && c <= 5));
            if (c == 1) begin
                chk("wr_mem_wr", bus.mem_wr, 1);
                chk("wr_mem_addr", bus.mem_addr, 16'h0040);
                chk("wr_mem_data_in", bus.mem_data_in, 16'hBEEF);
            end
            next_cycle();
        end

        // Simultaneous I and D fill requests
        bus.ic_fill_addr = 16'h4410;
        bus.dc_fill_addr = 16'h2008;
        bus.ic_fill_req  = 1'b1;
        icwe_early = 0;
        for (int c = 0; c <= 14; c++) begin
            bus.dc_fill_req = (c <= 12);
            @(negedge clk);
            if (bus.ic_fill_we) icwe_early++;
            if (c == 1) chk("sim_d_first_addr", bus.mem_addr, 16'h2000);
            chk($sformatf("sim_dc_done_c%0d", c), bus.dc_fill_done, (c == 12));
            if (c == 13) begin
                chk("sim_gap_busy", bus.busy, 0);
                chk("sim_gap_en", bus.mem_enable, 0);
            end
            if (c == 14) begin
                chk("sim_i_first_en", bus.mem_enable, 1);
                chk("sim_i_first_addr", bus.mem_addr, 16'h4410);
            end
            next_cycle();
        end
        chk("sim_no_early_ic_we", icwe_early, 0);
        n = 0;
        found = 1'b0;
        dcyc = 0;
        while (n < 20 && !found) begin
            @(negedge clk);
            if (bus.ic_fill_done) begin
                found = 1'b1;
                dcyc  = 15 + n;
            end
            next_cycle();
            n++;
        end
        bus.ic_fill_req = 1'b0;
        chk("sim_ic_done_seen", found, 1);
        chk("sim_ic_done_cycle", dcyc, 25);

        // Continuous D traffic with a waiting I requester
        bus.dc_wr_addr   = 16'h0100;
        bus.dc_wr_data   = 16'h1111;
        bus.dc_fill_addr = 16'h2000;
        bus.ic_fill_addr = 16'h4400;
        bus.dc_wr_req    = 1'b1;
        bus.dc_fill_req  = 1'b1;
        bus.ic_fill_req  = 1'b1;
        icount = 0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            wd = bus.dc_wr_done;
            fd = bus.dc_fill_done;
            id = bus.ic_fill_done;
            if (bus.ic_fill_we) icount++;
            if (wd || fd) sides.push_back(1'b1);
            if (id) sides.push_back(1'b0);
            next_cycle();
            bus.dc_wr_req   = !wd;
            bus.dc_fill_req = !fd;
            bus.ic_fill_req = !id;
        end
        bus.dc_wr_req   = 1'b0;
        bus.dc_fill_req = 1'b0;
        bus.ic_fill_req = 1'b0;
        n = 0;
        while (n < 30 && bus.busy) begin
            next_cycle();
            n++;
        end
        chk("arb_drain_idle", bus.busy, 0);
        chk("arb_done_count_ge8", (sides.size() >= 8), 1);
`ifdef MEM_ARB_RR_EN
        chk("arb_ic_served", (icount > 0), 1);
        for (int k = 0; k < 8 && k < sides.size(); k++)
            chk($sformatf("rr_side_%0d", k), sides[k], (k % 2 == 0));
`else
        chk("arb_ic_starved", icount, 0);
        for (int k = 0; k < 8 && k < sides.size(); k++)
            chk($sformatf("fixed_side_%0d", k), sides[k], 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
